// File: rtl/pipeline_hazard_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_controller_pkg
//  Description : Shared types and constants for the pipeline hazard controller.
//  Revision    : 1.0
// ============================================================================

package pipeline_hazard_controller_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam int unsigned C_DEFAULT_MUL_LATENCY = 2;
    localparam int unsigned C_DEFAULT_DIV_LATENCY = 33;
    localparam int unsigned C_DEFAULT_CNT_W       = 6;
    localparam logic [4:0]  C_REG_ZERO            = 5'd0;

    // EX occupancy of the M-extension op currently in EX.
    function automatic int unsigned f_select_latency(
        input logic        is_div,
        input int unsigned mul_lat,
        input int unsigned div_lat
    );
        return is_div ? div_lat : mul_lat;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_controller_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_controller_muldiv_sequencer
//  Description : Holds EX for the occupancy of a multi-cycle M-extension op
//                and generates the start/done pulses for the M unit.
//  Revision    : 1.0
// ============================================================================

module pipeline_hazard_controller_muldiv_sequencer
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = C_DEFAULT_MUL_LATENCY,
    parameter int unsigned DIV_LATENCY = C_DEFAULT_DIV_LATENCY,
    parameter int unsigned CNT_W       = C_DEFAULT_CNT_W
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ex_muldiv_valid,
    input  logic ex_is_div,
    output logic muldiv_hold,
    output logic muldiv_start,
    output logic muldiv_done,
    output logic md_busy
);

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    md_state_t        r_state;
    md_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_lat;

    assign w_lat   = CNT_W'(f_select_latency(ex_is_div, MUL_LATENCY, DIV_LATENCY));
    assign md_busy = (r_state == MD_BUSY);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outputs are gated by RESET so an aborted op never emits a done pulse.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        muldiv_hold  = 1'b0;
        muldiv_start = 1'b0;
        muldiv_done  = 1'b0;
        if (!RESET) begin
            case (r_state)
                IDLE: begin
                    if (ex_muldiv_valid) begin
                        muldiv_start = 1'b1;
                        if (w_lat == C_ONE) begin
                            muldiv_done = 1'b1;
                        end else begin
                            muldiv_hold = 1'b1;
                            w_cnt_nxt   = w_lat - C_ONE;
                            w_state_nxt = MD_BUSY;
                        end
                    end
                end
                MD_BUSY: begin
                    w_cnt_nxt = r_cnt - C_ONE;
                    if (r_cnt == C_ONE) begin
                        muldiv_done = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        muldiv_hold = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_controller
//  Description : Stall/flush sequencer for the 5-stage RV32IM pipeline with
//                stall and branch-flush performance counters.
//  Revision    : 1.0
// ============================================================================

module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = C_DEFAULT_MUL_LATENCY,
    parameter int unsigned DIV_LATENCY = C_DEFAULT_DIV_LATENCY,
    parameter int unsigned CNT_W       = C_DEFAULT_CNT_W
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        ex_muldiv_valid,
    input  logic        ex_is_div,
    input  logic        imem_busy,
    output logic        pc_write_en,
    output logic        ifid_write_en,
    output logic        ifid_flush,
    output logic        idex_write_en,
    output logic        idex_flush,
    output logic        ex_hold,
    output logic        muldiv_start,
    output logic        muldiv_done,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    logic        w_md_hold;
    logic        w_md_busy;
    logic        w_load_use;
    logic        w_branch_flush;
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;

    pipeline_hazard_controller_muldiv_sequencer #(
        .MUL_LATENCY (MUL_LATENCY),
        .DIV_LATENCY (DIV_LATENCY),
        .CNT_W       (CNT_W)
    ) u_muldiv_sequencer (
        .CLK             (CLK),
        .RESET           (RESET),
        .ex_muldiv_valid (ex_muldiv_valid),
        .ex_is_div       (ex_is_div),
        .muldiv_hold     (w_md_hold),
        .muldiv_start    (muldiv_start),
        .muldiv_done     (muldiv_done),
        .md_busy         (w_md_busy)
    );

    assign w_load_use = ex_mem_read && (ex_rd != C_REG_ZERO) &&
                        ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                         (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        pc_write_en    = 1'b1;
        ifid_write_en  = 1'b1;
        idex_write_en  = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        ex_hold        = 1'b0;
        w_branch_flush = 1'b0;
        if (RESET) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_write_en = 1'b0;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
        end else if (w_md_hold) begin
            ex_hold       = 1'b1;
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_write_en = 1'b0;
        end else if (ex_branch_taken) begin
            // Redirect wins over load-use and imem wait: the fetch is aborted.
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            w_branch_flush = 1'b1;
        end else if (w_load_use) begin
            // IF/ID is held rather than flushed so the consumer survives.
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_flush    = 1'b1;
        end else if (imem_busy) begin
            pc_write_en = 1'b0;
            ifid_flush  = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (!pc_write_en) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_branch_flush) begin
                r_flush_events <= r_flush_events + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;

    a_no_branch_with_muldiv : assert property (
        @(posedge CLK) disable iff (RESET) !(ex_branch_taken && ex_muldiv_valid));
    a_no_branch_in_md_busy : assert property (
        @(posedge CLK) disable iff (RESET) !(ex_branch_taken && w_md_busy));

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_controller
//  Description : Self-checking bench: directed scenarios plus randomized
//                traffic against a cycle-level behavioural model.
//  Revision    : 1.0
// ============================================================================

module tb_pipeline_hazard_controller;

    localparam int unsigned MUL_LAT   = 2;
    localparam int unsigned DIV_LAT   = 33;
    localparam int unsigned B_DIV_LAT = 3;

    // Control vector order: pc_we, ifid_we, idex_we, ifid_flush, idex_flush, ex_hold, start, done
    localparam logic [7:0] C_RST   = 8'b0001_1000;
    localparam logic [7:0] C_DEF   = 8'b1110_0000;
    localparam logic [7:0] C_LU    = 8'b0010_1000;
    localparam logic [7:0] C_BR    = 8'b1111_1000;
    localparam logic [7:0] C_IMEM  = 8'b0111_0000;
    localparam logic [7:0] C_HOLD  = 8'b0000_0100;
    localparam logic [7:0] C_START = 8'b0000_0110;
    localparam logic [7:0] C_DONE  = 8'b1110_0001;
    localparam logic [7:0] C_ONE   = 8'b1110_0011;

    logic        CLK;
    logic        RESET;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic        ex_branch_taken, ex_muldiv_valid, ex_is_div, imem_busy;
    logic        pc_write_en, ifid_write_en, ifid_flush, idex_write_en, idex_flush;
    logic        ex_hold, muldiv_start, muldiv_done;
    logic [31:0] stall_cycles, flush_events;

    logic        b_valid, b_is_div;
    logic        b_pc_we, b_ifid_we, b_ifid_fl, b_idex_we, b_idex_fl, b_hold, b_start, b_done;
    logic [31:0] b_stall, b_flush;

    logic [7:0]  ctl, b_ctl;
    int          n_checks = 0;
    int          n_errors = 0;

    assign ctl   = {pc_write_en, ifid_write_en, idex_write_en, ifid_flush, idex_flush,
                    ex_hold, muldiv_start, muldiv_done};
    assign b_ctl = {b_pc_we, b_ifid_we, b_idex_we, b_ifid_fl, b_idex_fl, b_hold, b_start, b_done};

    pipeline_hazard_controller #(
        .MUL_LATENCY (MUL_LAT),
        .DIV_LATENCY (DIV_LAT),
        .CNT_W       (6)
    ) u_dut (
        .CLK (CLK), .RESET (RESET),
        .id_rs1 (id_rs1), .id_rs2 (id_rs2),
        .id_uses_rs1 (id_uses_rs1), .id_uses_rs2 (id_uses_rs2),
        .ex_mem_read (ex_mem_read), .ex_rd (ex_rd),
        .ex_branch_taken (ex_branch_taken), .ex_muldiv_valid (ex_muldiv_valid),
        .ex_is_div (ex_is_div), .imem_busy (imem_busy),
        .pc_write_en (pc_write_en), .ifid_write_en (ifid_write_en), .ifid_flush (ifid_flush),
        .idex_write_en (idex_write_en), .idex_flush (idex_flush), .ex_hold (ex_hold),
        .muldiv_start (muldiv_start), .muldiv_done (muldiv_done),
        .stall_cycles (stall_cycles), .flush_events (flush_events)
    );

    // Second instance exercises single-cycle multiply and a short divide.
    pipeline_hazard_controller #(
        .MUL_LATENCY (1),
        .DIV_LATENCY (B_DIV_LAT),
        .CNT_W       (2)
    ) u_dut_b (
        .CLK (CLK), .RESET (RESET),
        .id_rs1 (5'd0), .id_rs2 (5'd0),
        .id_uses_rs1 (1'b0), .id_uses_rs2 (1'b0),
        .ex_mem_read (1'b0), .ex_rd (5'd0),
        .ex_branch_taken (1'b0), .ex_muldiv_valid (b_valid),
        .ex_is_div (b_is_div), .imem_busy (1'b0),
        .pc_write_en (b_pc_we), .ifid_write_en (b_ifid_we), .ifid_flush (b_ifid_fl),
        .idex_write_en (b_idex_we), .idex_flush (b_idex_fl), .ex_hold (b_hold),
        .muldiv_start (b_start), .muldiv_done (b_done),
        .stall_cycles (b_stall), .flush_events (b_flush)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0; ex_branch_taken = 1'b0;
        ex_muldiv_valid = 1'b0; ex_is_div = 1'b0; imem_busy = 1'b0;
        b_valid = 1'b0; b_is_div = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        drive_idle();
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        drive_idle();
        imem_busy = 1'b1;
        repeat (3) @(negedge CLK);
        #2;
        RESET = 1'b1;
        ex_muldiv_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_RST) begin n_errors++; $display("FAIL reset_ctl: got %b want %b", ctl, C_RST); end
        n_checks++;
        if (b_ctl !== C_RST) begin n_errors++; $display("FAIL reset_ctl_b: got %b want %b", b_ctl, C_RST); end
        n_checks++;
        if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cycles, flush_events);
        end
        @(negedge CLK);
        drive_idle();
        RESET = 1'b0;
    endtask

    task automatic test_no_hazard();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            id_rs1 = 5'($urandom_range(1, 10));
            id_rs2 = 5'($urandom_range(11, 20));
            ex_rd  = 5'($urandom_range(21, 31));
            id_uses_rs1 = 1'($urandom_range(0, 1));
            id_uses_rs2 = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (ctl !== C_DEF) begin n_errors++; $display("FAIL alu_op_%0d: got %b want %b", i, ctl, C_DEF); end
        end
        @(negedge CLK);
        drive_idle();
        #1;
        n_checks++;
        if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
            n_errors++;
            $display("FAIL alu_counters: got %0d/%0d want 0/0", stall_cycles, flush_events);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge CLK);
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd1;
        id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_LU) begin n_errors++; $display("FAIL lu_rs1: got %b want %b", ctl, C_LU); end
        @(negedge CLK);
        ex_mem_read = 1'b0; ex_rd = 5'd0;
        #1;
        n_checks++;
        if (ctl !== C_DEF || stall_cycles !== 32'd1) begin
            n_errors++;
            $display("FAIL lu_release: got %b/%0d want %b/1", ctl, stall_cycles, C_DEF);
        end
        @(negedge CLK);
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd7; id_rs2 = 5'd9;
        #1;
        n_checks++;
        if (ctl !== C_LU) begin n_errors++; $display("FAIL lu_rs2: got %b want %b", ctl, C_LU); end
        @(negedge CLK);
        id_uses_rs2 = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_DEF) begin n_errors++; $display("FAIL lu_unused_src: got %b want %b", ctl, C_DEF); end
        @(negedge CLK);
        ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs2 = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_DEF) begin n_errors++; $display("FAIL lu_x0: got %b want %b", ctl, C_DEF); end
        @(negedge CLK);
        drive_idle();
        #1;
        n_checks++;
        if (stall_cycles !== 32'd2) begin n_errors++; $display("FAIL lu_stall_count: got %0d want 2", stall_cycles); end
    endtask

    task automatic test_divide();
        logic [7:0] exp;
        int         holds = 0;
        do_reset();
        for (int t = 0; t <= 32; t++) begin
            @(negedge CLK);
            ex_muldiv_valid = 1'b1; ex_is_div = 1'b1;
            #1;
            exp = (t == 0) ? C_START : (t < 32) ? C_HOLD : C_DONE;
            if (ex_hold) holds++;
            n_checks++;
            if (ctl !== exp) begin n_errors++; $display("FAIL div_t%0d: got %b want %b", t, ctl, exp); end
        end
        @(negedge CLK);
        drive_idle();
        #1;
        n_checks++;
        if (ctl !== C_DEF || stall_cycles !== 32'd32 || holds != 32) begin
            n_errors++;
            $display("FAIL div_summary: ctl %b stall %0d holds %0d want %b 32 32", ctl, stall_cycles, holds, C_DEF);
        end
    endtask

    task automatic test_multiply();
        logic [7:0] exp;
        do_reset();
        @(negedge CLK);
        ex_muldiv_valid = 1'b1; ex_is_div = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_START) begin n_errors++; $display("FAIL mul2_t0: got %b want %b", ctl, C_START); end
        @(negedge CLK);
        #1;
        n_checks++;
        if (ctl !== C_DONE) begin n_errors++; $display("FAIL mul2_t1: got %b want %b", ctl, C_DONE); end
        @(negedge CLK);
        drive_idle();
        b_valid = 1'b1; b_is_div = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_DEF || stall_cycles !== 32'd1) begin
            n_errors++;
            $display("FAIL mul2_after: got %b/%0d want %b/1", ctl, stall_cycles, C_DEF);
        end
        n_checks++;
        if (b_ctl !== C_ONE) begin n_errors++; $display("FAIL mul1_same_cycle: got %b want %b", b_ctl, C_ONE); end
        for (int t = 0; t <= 3; t++) begin
            @(negedge CLK);
            b_valid = (t < 3); b_is_div = 1'b1;
            #1;
            exp = (t == 0) ? C_START : (t == 1) ? C_HOLD : (t == 2) ? C_DONE : C_DEF;
            n_checks++;
            if (b_ctl !== exp) begin n_errors++; $display("FAIL div3_t%0d: got %b want %b", t, b_ctl, exp); end
        end
        n_checks++;
        if (b_stall !== 32'd2) begin n_errors++; $display("FAIL div3_stall: got %0d want 2", b_stall); end
        @(negedge CLK);
        drive_idle();
    endtask

    task automatic test_simultaneous();
        do_reset();
        @(negedge CLK);
        ex_branch_taken = 1'b1; imem_busy = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_BR) begin n_errors++; $display("FAIL br_lu_imem: got %b want %b", ctl, C_BR); end
        @(negedge CLK);
        ex_branch_taken = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_LU || flush_events !== 32'd1) begin
            n_errors++;
            $display("FAIL lu_imem: got %b/%0d want %b/1", ctl, flush_events, C_LU);
        end
        @(negedge CLK);
        ex_mem_read = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_IMEM) begin n_errors++; $display("FAIL imem_only: got %b want %b", ctl, C_IMEM); end
        @(negedge CLK);
        ex_muldiv_valid = 1'b1; ex_is_div = 1'b0; ex_mem_read = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_START) begin n_errors++; $display("FAIL mul_over_all: got %b want %b", ctl, C_START); end
        @(negedge CLK);
        ex_mem_read = 1'b0;
        #1;
        n_checks++;
        if (ctl !== 8'b0111_0001) begin n_errors++; $display("FAIL done_with_imem: got %b want 01110001", ctl); end
        @(negedge CLK);
        drive_idle();
        #1;
        n_checks++;
        if (stall_cycles !== 32'd4 || flush_events !== 32'd1) begin
            n_errors++;
            $display("FAIL simul_counters: got %0d/%0d want 4/1", stall_cycles, flush_events);
        end
    endtask

    task automatic test_abort();
        do_reset();
        for (int t = 0; t < 10; t++) begin
            @(negedge CLK);
            ex_muldiv_valid = 1'b1; ex_is_div = 1'b1;
        end
        @(negedge CLK);
        #1;
        n_checks++;
        if (ctl !== C_HOLD) begin n_errors++; $display("FAIL abort_pre: got %b want %b", ctl, C_HOLD); end
        #2;
        RESET = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_RST || stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
            n_errors++;
            $display("FAIL abort_reset: got %b/%0d/%0d want %b/0/0", ctl, stall_cycles, flush_events, C_RST);
        end
        @(negedge CLK);
        ex_muldiv_valid = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_DEF) begin n_errors++; $display("FAIL abort_idle: got %b want %b", ctl, C_DEF); end
        @(negedge CLK);
        ex_muldiv_valid = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_START) begin n_errors++; $display("FAIL abort_restart: got %b want %b", ctl, C_START); end
        @(negedge CLK);
        drive_idle();
        RESET = 1'b1;
    endtask

    task automatic test_random();
        bit          md_active = 1'b0;
        int          md_idx = 0;
        int          md_lat = 0;
        bit          s, d, h, lu;
        logic [7:0]  exp;
        logic [31:0] exp_stall = 32'd0;
        logic [31:0] exp_flush = 32'd0;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            @(negedge CLK);
            if (md_active) begin
                ex_muldiv_valid = 1'b1;
                ex_branch_taken = 1'b0;
            end else begin
                ex_muldiv_valid = ($urandom_range(0, 9) == 0);
                ex_is_div       = 1'($urandom_range(0, 1));
                ex_branch_taken = !ex_muldiv_valid && ($urandom_range(0, 4) == 0);
            end
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom_range(0, 1));
            id_uses_rs2 = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            imem_busy   = ($urandom_range(0, 3) == 0);
            #1;
            s = 1'b0; d = 1'b0; h = 1'b0;
            if (!md_active && ex_muldiv_valid) begin
                md_active = 1'b1;
                md_idx    = 0;
                md_lat    = ex_is_div ? int'(DIV_LAT) : int'(MUL_LAT);
                s         = 1'b1;
            end
            if (md_active) begin
                h = (md_idx < md_lat - 1);
                d = (md_idx == md_lat - 1);
            end
            lu = ex_mem_read && (ex_rd != 5'd0) &&
                 ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
            if (h)                    exp = C_HOLD;
            else if (ex_branch_taken) exp = C_BR;
            else if (lu)              exp = C_LU;
            else if (imem_busy)       exp = C_IMEM;
            else                      exp = C_DEF;
            exp[1] = s;
            exp[0] = d;
            n_checks++;
            if (ctl !== exp) begin n_errors++; $display("FAIL rand_ctl_c%0d: got %b want %b", c, ctl, exp); end
            n_checks++;
            if (stall_cycles !== exp_stall || flush_events !== exp_flush) begin
                n_errors++;
                $display("FAIL rand_cnt_c%0d: got %0d/%0d want %0d/%0d", c, stall_cycles, flush_events,
                         exp_stall, exp_flush);
            end
            if (md_active) begin
                md_idx++;
                if (d) md_active = 1'b0;
            end
            if (!exp[7]) exp_stall++;
            if (!h && ex_branch_taken) exp_flush++;
        end
        @(negedge CLK);
        drive_idle();
    endtask

    initial begin
        drive_idle();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        test_reset();
        test_no_hazard();
        test_load_use();
        test_divide();
        test_multiply();
        test_simultaneous();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage RV32IM pipeline.
- Drives the write-enable and flush controls of the PC, the IF/ID register and the ID/EX register, and freezes EX during multi-cycle M-extension ops.
- Resolves load-use hazards, taken-branch/jump redirects and instruction-memory wait states.
- Keeps stall and flush performance counters.

Parameters:
- MUL_LATENCY, 2: EX occupancy in cycles for MUL/MULH/MULHSU/MULHU; must be >= 1.
- DIV_LATENCY, 33: EX occupancy in cycles for DIV/DIVU/REM/REMU; must be >= 1.
- CNT_W, 6: width of the latency counter; must satisfy 2^CNT_W > max(MUL_LATENCY, DIV_LATENCY).

Ports:
- CLK  in  1  clock (rising edge).
- RESET  in  1  asynchronous, active-high reset.
- id_rs1, id_rs2  in  5 each  source register fields of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction reads that source.
- ex_mem_read  in  1  the instruction in EX is a load.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_branch_taken  in  1  EX resolved a taken branch or a jump.
- ex_muldiv_valid  in  1  the instruction in EX is an M-extension op.
- ex_is_div  in  1  qualifies ex_muldiv_valid: 1 = div/rem, 0 = mul.
- imem_busy  in  1  instruction memory cannot deliver this cycle.
- pc_write_en  out  1  PC update enable.
- ifid_write_en  out  1  IF/ID load enable.
- ifid_flush  out  1  load a NOP into IF/ID; overrides ifid_write_en.
- idex_write_en  out  1  ID/EX load enable.
- idex_flush  out  1  load a bubble into ID/EX; overrides idex_write_en.
- ex_hold  out  1  EX stage frozen; EX/MEM receives a bubble.
- muldiv_start  out  1  one-cycle pulse that starts the M unit.
- muldiv_done  out  1  one-cycle pulse; the M result is valid in EX.
- stall_cycles  out  32  count of cycles with pc_write_en=0.
- flush_events  out  32  count of cycles with ifid_flush=1 caused by a branch.

Behaviour:
- RESET is asynchronous: state<=IDLE, cnt<=0, both counters<=0.
- While RESET=1: pc_write_en, ifid_write_en, idex_write_en = 0; ifid_flush, idex_flush = 1; ex_hold, muldiv_start, muldiv_done = 0.
- States: IDLE, MD_BUSY. All outputs are combinational from state, cnt and inputs.
- Default (no hazard): all write enables 1, all flushes, holds and pulses 0.
- lat = ex_is_div ? DIV_LATENCY : MUL_LATENCY.
- Priority, highest first:
  - (1) muldiv hold
  - (2) branch redirect
  - (3) load-use
  - (4) imem_busy
- (1) Start in IDLE when ex_muldiv_valid=1:
  - muldiv_start=1.
  - If lat==1: no hold, muldiv_done=1 in the same cycle.
  - Otherwise: ex_hold=1, pc/ifid/idex write enables=0, cnt<=lat-1, next state MD_BUSY.
- (1) In MD_BUSY, every cycle:
  - cnt<=cnt-1.
  - While cnt!=1: hold as on the start cycle.
  - When cnt==1: hold released (default outputs), muldiv_done=1, next state IDLE.
  - Total hold cycles = lat-1; the result is consumed on cycle lat.
  - ex_muldiv_valid is ignored in MD_BUSY (it is still the same instruction).
- (2) ex_branch_taken=1 in IDLE:
  - ifid_flush=1, idex_flush=1, pc_write_en=1.
  - flush_events increments.
  - Overrides a simultaneous load-use (the ID instruction dies anyway).
  - Overrides imem_busy (PC redirects; imem aborts the outstanding fetch).
- (3) Load-use condition: ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
  - Response: pc_write_en=0, ifid_write_en=0, idex_flush=1, for exactly 1 cycle.
  - Takes precedence over imem_busy: IF/ID is held, not flushed, so the ID instruction is preserved.
- (4) imem_busy=1 with no higher-priority event: pc_write_en=0, ifid_flush=1; ID/EX and later stages advance.
- Illegal input combinations, checked by assertion in simulation:
  - ex_branch_taken together with ex_muldiv_valid.
  - ex_branch_taken in MD_BUSY.
- Counters: 32-bit, wrap modulo 2^32, count only while RESET=0.
- RESET asserted in MD_BUSY aborts the operation: no muldiv_done pulse; the M unit is reset by the same RESET.

Decomposition:
- Shared package: state enum (IDLE, MD_BUSY), default MUL/DIV latency constants, register-index zero constant.
- One sub-module, muldiv_sequencer:
  - Contains the state register, latency counter and start/done/hold generation.
  - The top level adds the hazard priority logic and the counters.

Test Plan:
- Reset and no hazards: RESET high mid-run, then released; 10 independent ALU ops -> write enables 1 throughout, stall_cycles=0, flush_events=0.
- Load-use: load x5 in EX, ID add x6,x5,x1 -> exactly 1 cycle of pc_write_en=0 and idex_flush=1; ex_rd=0 -> no stall.
- Divide: DIV in EX, DIV_LATENCY=33 -> muldiv_start at t0, ex_hold high for 32 cycles, muldiv_done at t32, stall_cycles=32.
- Multiply, MUL_LATENCY=1 -> muldiv_start and muldiv_done in the same cycle, no stall; MUL_LATENCY=2 -> 1 hold cycle.
- Simultaneous events: branch taken with load-use and imem_busy -> ifid_flush=1, idex_flush=1, pc_write_en=1, flush_events+1; load-use with imem_busy -> ifid_write_en=0, ifid_flush=0.
- Abort: RESET at cycle 10 of a DIV -> state IDLE, no done pulse, counters 0.
